// File: rtl/count_mod10_pkg.sv
// Shared types and constants for the mod-10 counter tracker.
package count_mod10_pkg;

  localparam int unsigned CNT_W = 4;

  localparam logic [CNT_W-1:0] MOD_MAX   = 4'd9;
  localparam logic             MODE_UP   = 1'b1;
  localparam logic             MODE_DOWN = 1'b0;

  typedef enum logic [1:0] {
    ST_UNSYNC = 2'd0,
    ST_SYNC   = 2'd1,
    ST_FAULT  = 2'd2
  } trk_state_e;

  // Counter control inputs as seen by the counter on one edge.
  typedef struct packed {
    logic             rst;
    logic             load;
    logic             mode;
    logic [CNT_W-1:0] data_in;
  } cnt_ctrl_t;

endpackage

// File: rtl/count_mod10_model.sv
// Combinational next-value model of the mod-10 up/down counter.
module count_mod10_model
  import count_mod10_pkg::*;
(
  input  cnt_ctrl_t        ctrl,
  input  logic [CNT_W-1:0] value,
  output logic [CNT_W-1:0] next_value_c,
  output logic             wrap_up_c,
  output logic             wrap_dn_c
);

  // Priority: reset > load > direction; values above 9 step as plain 4-bit.
  always_comb begin
    next_value_c = value;
    wrap_up_c    = 1'b0;
    wrap_dn_c    = 1'b0;
    if (ctrl.rst) begin
      next_value_c = '0;
    end else if (ctrl.load) begin
      next_value_c = ctrl.data_in;
    end else if (ctrl.mode == MODE_UP) begin
      if (value == MOD_MAX) begin
        next_value_c = '0;
        wrap_up_c    = 1'b1;
      end else begin
        next_value_c = value + CNT_W'(1);
      end
    end else if (ctrl.mode == MODE_DOWN) begin
      if (value == '0) begin
        next_value_c = MOD_MAX;
        wrap_dn_c    = 1'b1;
      end else begin
        next_value_c = value - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/count_mod10_tracker.sv
// Passive checker that predicts and verifies each mod-10 counter output.
module count_mod10_tracker
  import count_mod10_pkg::*;
#(
  parameter int unsigned WRAP_W = 8,
  parameter int unsigned ERR_W  = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cnt_reset,
  input  logic                     cnt_load,
  input  logic                     cnt_mode,
  input  logic [CNT_W-1:0]         cnt_data_in,
  input  logic [CNT_W-1:0]         cnt_data_out,
  input  logic                     clear_err,
  output logic [1:0]               state,
  output logic [CNT_W-1:0]         expected,
  output logic                     carry,
  output logic                     borrow,
  output logic signed [WRAP_W-1:0] wrap_count,
  output logic                     err_pulse,
  output logic                     err_sticky,
  output logic [ERR_W-1:0]         err_count,
  output logic                     range_warn
);

  localparam logic signed [WRAP_W-1:0] WRAP_MAX = {1'b0, {(WRAP_W-1){1'b1}}};
  localparam logic signed [WRAP_W-1:0] WRAP_MIN = {1'b1, {(WRAP_W-1){1'b0}}};
  localparam logic [ERR_W-1:0]         ERR_MAX  = '1;

  trk_state_e       state_q;
  logic             exp_valid_q;
  logic             wrap_up_q;
  logic             wrap_dn_q;
  cnt_ctrl_t        ctrl_c;
  logic [CNT_W-1:0] next_c;
  logic             wrap_up_c;
  logic             wrap_dn_c;
  logic             resync_c;
  logic             checking_c;
  logic             hit_c;
  logic             mismatch_c;

  // Bundle the snooped controls for the model.
  always_comb begin
    ctrl_c.rst     = cnt_reset;
    ctrl_c.load    = cnt_load;
    ctrl_c.mode    = cnt_mode;
    ctrl_c.data_in = cnt_data_in;
  end

  count_mod10_model u_model (
    .ctrl         (ctrl_c),
    .value        (cnt_data_out),
    .next_value_c (next_c),
    .wrap_up_c    (wrap_up_c),
    .wrap_dn_c    (wrap_dn_c)
  );

  assign resync_c   = cnt_reset | cnt_load;
  assign checking_c = (state_q == ST_SYNC) & exp_valid_q;
  assign hit_c      = checking_c & (cnt_data_out == expected);
  assign mismatch_c = checking_c & (cnt_data_out != expected);
  assign state      = 2'(state_q);

  // Tracker FSM: acquire lock on a reset/load, drop to FAULT on mismatch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_UNSYNC;
    end else begin
      case (state_q)
        ST_UNSYNC: if (resync_c) state_q <= ST_SYNC;
        ST_SYNC:   if (mismatch_c) state_q <= ST_FAULT;
        ST_FAULT: begin
          if (resync_c)       state_q <= ST_SYNC;
          else if (clear_err) state_q <= ST_UNSYNC;
        end
        default:   state_q <= ST_UNSYNC;
      endcase
    end
  end

  // Prediction for the next cycle's observed value and its wrap kind.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      expected    <= '0;
      exp_valid_q <= 1'b0;
      wrap_up_q   <= 1'b0;
      wrap_dn_q   <= 1'b0;
    end else begin
      expected    <= next_c;
      exp_valid_q <= resync_c | (state_q == ST_SYNC);
      wrap_up_q   <= wrap_up_c;
      wrap_dn_q   <= wrap_dn_c;
    end
  end

  // Event pulses, each one cycle after the compare.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      carry      <= 1'b0;
      borrow     <= 1'b0;
      err_pulse  <= 1'b0;
      range_warn <= 1'b0;
    end else begin
      carry      <= hit_c & wrap_up_q;
      borrow     <= hit_c & wrap_dn_q;
      err_pulse  <= mismatch_c;
      range_warn <= (state_q == ST_SYNC) & (cnt_data_out > MOD_MAX);
    end
  end

  // Saturating signed net wrap counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrap_count <= '0;
    end else if (hit_c & wrap_up_q) begin
      if (wrap_count != WRAP_MAX) wrap_count <= wrap_count + WRAP_W'(1);
    end else if (hit_c & wrap_dn_q) begin
      if (wrap_count != WRAP_MIN) wrap_count <= wrap_count - WRAP_W'(1);
    end
  end

  // Error flag and saturating count; a same-cycle mismatch beats clear_err.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else if (mismatch_c) begin
      err_sticky <= 1'b1;
      if (clear_err)                 err_count <= ERR_W'(1);
      else if (err_count != ERR_MAX) err_count <= err_count + ERR_W'(1);
    end else if (clear_err) begin
      err_sticky <= 1'b0;
      err_count  <= '0;
    end
  end

endmodule

// File: tb/tb_count_mod10_tracker.sv
// Scoreboard bench for count_mod10_tracker with a behavioural counter beside it.
module tb_count_mod10_tracker;
  import count_mod10_pkg::*;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              cnt_reset = 1'b0;
  logic              cnt_load = 1'b0;
  logic              cnt_mode = 1'b0;
  logic [3:0]        cnt_data_in = 4'd0;
  logic [3:0]        cnt_data_out;
  logic              clear_err = 1'b0;
  logic [1:0]        state;
  logic [3:0]        expected;
  logic              carry;
  logic              borrow;
  logic signed [7:0] wrap_count;
  logic              err_pulse;
  logic              err_sticky;
  logic [7:0]        err_count;
  logic              range_warn;

  logic [3:0] cnt_q = 4'd0;
  logic       force_en = 1'b0;
  logic [3:0] force_val = 4'd0;

  typedef struct packed {
    logic              carry;
    logic              borrow;
    logic              err;
    logic              rw;
    logic [1:0]        st;
    logic signed [7:0] wc;
    logic [7:0]        ec;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_got;
  ev_t mon_exp;
  int  n_checks = 0;
  int  n_fail = 0;
  int  exp_wc;

  count_mod10_tracker #(.WRAP_W(8), .ERR_W(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .cnt_reset    (cnt_reset),
    .cnt_load     (cnt_load),
    .cnt_mode     (cnt_mode),
    .cnt_data_in  (cnt_data_in),
    .cnt_data_out (cnt_data_out),
    .clear_err    (clear_err),
    .state        (state),
    .expected     (expected),
    .carry        (carry),
    .borrow       (borrow),
    .wrap_count   (wrap_count),
    .err_pulse    (err_pulse),
    .err_sticky   (err_sticky),
    .err_count    (err_count),
    .range_warn   (range_warn)
  );

  always #5 clock = ~clock;

  // The counter being snooped; force_en injects a wrong observed value.
  always @(posedge clock) begin
    if (cnt_reset)     cnt_q <= 4'd0;
    else if (cnt_load) cnt_q <= cnt_data_in;
    else if (cnt_mode) cnt_q <= (cnt_q == 4'd9) ? 4'd0 : cnt_q + 4'd1;
    else               cnt_q <= (cnt_q == 4'd0) ? 4'd9 : cnt_q - 4'd1;
  end

  assign cnt_data_out = force_en ? force_val : cnt_q;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic push_ev(input logic c, input logic b, input logic e, input logic r,
                         input logic [1:0] st, input int wc, input int ec);
    ev_t t;
    t.carry  = c;
    t.borrow = b;
    t.err    = e;
    t.rw     = r;
    t.st     = st;
    t.wc     = 8'(wc);
    t.ec     = 8'(ec);
    exp_q.push_back(t);
  endtask

  task automatic cyc(input logic r, input logic ld, input logic md,
                     input logic [3:0] din, input logic clr);
    cnt_reset   = r;
    cnt_load    = ld;
    cnt_mode    = md;
    cnt_data_in = din;
    clear_err   = clr;
    @(posedge clock);
    #1;
  endtask

  initial begin
    fork
      // Monitor: every cycle with a pulse must match the next queued event.
      forever begin
        @(negedge clock);
        if (!reset && (carry || borrow || err_pulse || range_warn)) begin
          mon_got.carry  = carry;
          mon_got.borrow = borrow;
          mon_got.err    = err_pulse;
          mon_got.rw     = range_warn;
          mon_got.st     = state;
          mon_got.wc     = wrap_count;
          mon_got.ec     = err_count;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got %h, expected none", mon_got);
          end else begin
            mon_exp = exp_q.pop_front();
            if (mon_got !== mon_exp) begin
              n_fail++;
              $display("FAIL event: got %h (c%0b b%0b e%0b r%0b st%0d wc%0d ec%0d), expected %h (c%0b b%0b e%0b r%0b st%0d wc%0d ec%0d)",
                       mon_got, mon_got.carry, mon_got.borrow, mon_got.err, mon_got.rw,
                       mon_got.st, mon_got.wc, mon_got.ec,
                       mon_exp, mon_exp.carry, mon_exp.borrow, mon_exp.err, mon_exp.rw,
                       mon_exp.st, mon_exp.wc, mon_exp.ec);
            end
          end
        end
      end

      begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected stimulus completion");
      end

      begin
        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("reset_state", state, ST_UNSYNC);
        check("reset_expected", expected, 0);
        check("reset_wrap", wrap_count, 0);
        check("reset_errcnt", err_count, 0);
        reset = 1'b0;

        // 1: cnt_reset then up x12, carry on 9->0
        cyc(1, 0, 1, 0, 0);
        for (int i = 1; i <= 12; i++) begin
          if (i == 11) push_ev(1, 0, 0, 0, ST_SYNC, 1, 0);
          cyc(0, 0, 1, 0, 0);
        end
        check("t1_state", state, ST_SYNC);
        check("t1_wrap", wrap_count, 1);
        check("t1_errcnt", err_count, 0);

        // 2: fresh tracker, cnt_reset then down x3: 0,9,8,7 with borrow
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("t2_exp9", expected, 9);
        push_ev(0, 1, 0, 0, ST_SYNC, -1, 0);
        cyc(0, 0, 0, 0, 0);
        check("t2_exp8", expected, 8);
        cyc(0, 0, 0, 0, 0);
        check("t2_exp7", expected, 7);
        check("t2_wrap", wrap_count, -1);
        check("t2_errcnt", err_count, 0);

        // 3: load 4, observed 6 instead of 5, then resync by load 3
        cyc(0, 1, 0, 4, 0);
        cyc(0, 0, 1, 0, 0);
        force_en  = 1'b1;
        force_val = 4'd6;
        push_ev(0, 0, 1, 0, ST_FAULT, -1, 1);
        cyc(0, 0, 1, 0, 0);
        force_en = 1'b0;
        check("t3_state_fault", state, ST_FAULT);
        check("t3_errpulse", err_pulse, 1);
        check("t3_errcnt", err_count, 1);
        cyc(0, 1, 0, 3, 0);
        check("t3_errpulse_1cyc", err_pulse, 0);
        check("t3_state_resync", state, ST_SYNC);
        cyc(0, 0, 1, 0, 0);
        check("t3_sticky_kept", err_sticky, 1);
        check("t3_exp4", expected, 4);

        // 4: load 12, up x4: 13,14,15,0 with range_warn, no carry
        cyc(0, 1, 0, 12, 0);
        for (int i = 0; i < 4; i++) begin
          push_ev(0, 0, 0, 1, ST_SYNC, -1, 1);
          cyc(0, 0, 1, 0, 0);
        end
        cyc(0, 0, 1, 0, 0);
        check("t4_exp1", expected, 1);
        check("t4_wrap", wrap_count, -1);
        check("t4_errcnt", err_count, 1);

        // 5: saturate wrap_count at +127
        exp_wc = -1;
        cyc(1, 0, 1, 0, 0);
        for (int k = 0; k <= 130; k++) begin
          for (int j = 1; j <= 10; j++) begin
            if (k >= 1 && j == 1) begin
              if (exp_wc < 127) exp_wc++;
              push_ev(1, 0, 0, 0, ST_SYNC, exp_wc, 1);
            end
            cyc(0, 0, 1, 0, 0);
          end
        end
        check("t5_wrap_sat", wrap_count, 127);
        push_ev(1, 0, 0, 0, ST_SYNC, 127, 0);
        cyc(0, 0, 1, 0, 1);
        check("t5_clear_cnt", err_count, 0);
        check("t5_clear_sticky", err_sticky, 0);
        check("t5_wrap_still_sat", wrap_count, 127);
        force_en  = 1'b1;
        force_val = 4'd5;
        push_ev(0, 0, 1, 0, ST_FAULT, 127, 1);
        cyc(0, 0, 1, 0, 0);
        force_en = 1'b0;
        cyc(0, 1, 0, 7, 0);
        force_en  = 1'b1;
        force_val = 4'd0;
        push_ev(0, 0, 1, 0, ST_FAULT, 127, 1);
        cyc(0, 0, 1, 0, 1);
        force_en = 1'b0;
        check("t5_clear_vs_err_cnt", err_count, 1);
        check("t5_clear_vs_err_sticky", err_sticky, 1);
        cyc(0, 0, 1, 0, 1);
        check("t5_fault_clear_state", state, ST_UNSYNC);
        check("t5_fault_clear_cnt", err_count, 0);

        // 6: async reset between edges, then no checking until a load
        cyc(0, 1, 0, 2, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        check("t6_state_sync", state, ST_SYNC);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_state", state, ST_UNSYNC);
        check("t6_async_wrap", wrap_count, 0);
        check("t6_async_expected", expected, 0);
        @(posedge clock);
        #1;
        reset     = 1'b0;
        force_en  = 1'b1;
        force_val = 4'd11;
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        force_en = 1'b0;
        check("t6_unsync_state", state, ST_UNSYNC);
        check("t6_unsync_errcnt", err_count, 0);
        cyc(0, 1, 0, 5, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        check("t6_relock_state", state, ST_SYNC);
        check("t6_relock_errcnt", err_count, 0);
        check("t6_relock_exp7", expected, 7);

        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
      end
    join_any
    disable fork;

    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
